// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pkg
//  Purpose  : Shared definition of the 3-bit symbol cycle
//             000 -> 010 -> 011 -> 101 -> 000, used by both the generator
//             and the checker.
//  Revision : 1.0  initial release
// ============================================================================
package seq_pkg;

   // Legal symbols, in cycle order
   localparam logic [2:0] SYM_A = 3'b000;
   localparam logic [2:0] SYM_B = 3'b010;
   localparam logic [2:0] SYM_C = 3'b011;
   localparam logic [2:0] SYM_D = 3'b101;

   // Checker state encoding
   typedef enum logic [0:0] {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } seq_state_e;

   // Successor of a legal symbol; illegal symbols map to SYM_A
   function automatic logic [2:0] seq_next(input logic [2:0] sym);
      logic [2:0] nxt;
      case (sym)
         SYM_A:   nxt = SYM_B;
         SYM_B:   nxt = SYM_C;
         SYM_C:   nxt = SYM_D;
         SYM_D:   nxt = SYM_A;
         default: nxt = SYM_A;
      endcase
      return nxt;
   endfunction

   // True for the four symbols that belong to the cycle
   function automatic logic seq_legal(input logic [2:0] sym);
      return (sym == SYM_A) || (sym == SYM_B) || (sym == SYM_C) || (sym == SYM_D);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Up-counter that sticks at all-ones, with a synchronous clear
//             that takes priority over increment.
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Clear wins; otherwise increment unless already saturated
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && !(&count_q)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Count register with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/seq_checker.sv
`default_nettype none
// ============================================================================
//  Module   : seq_checker
//  Purpose  : Receive-side checker for the 3-bit symbol cycle. Hunts for
//             LOCK_LEN consecutive in-sequence symbols, then flywheels the
//             expected symbol and flags every deviation. Lock is dropped after
//             UNLOCK_ERRS consecutive mismatches.
//  Revision : 1.0  initial release
// ============================================================================
module seq_checker
   import seq_pkg::*;
#(
   parameter int LOCK_LEN    = 4,
   parameter int UNLOCK_ERRS = 3,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   input  logic [2:0]       in_sym_i,
   input  logic             clr_i,
   output logic             locked_o,
   output logic             err_o,
   output logic [CNT_W-1:0] err_count_o,
   output logic [CNT_W-1:0] sym_count_o
);

   localparam logic [3:0] c_lock_tgt   = 4'(LOCK_LEN);
   localparam logic [3:0] c_unlock_tgt = 4'(UNLOCK_ERRS);

   seq_state_e state_q, state_d;
   logic [2:0] expect_q, expect_d;
   logic [3:0] run_cnt_q, run_cnt_d;
   logic [3:0] miss_cnt_q, miss_cnt_d;
   logic       err_q, err_d;
   logic       err_inc;
   logic       sym_inc;
   logic       w_match;

   assign w_match = (in_sym_i == expect_q);

   // State register: FSM state, expected symbol, run/miss counters and err
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= HUNT;
         expect_q   <= SYM_A;
         run_cnt_q  <= 4'd0;
         miss_cnt_q <= 4'd0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         expect_q   <= expect_d;
         run_cnt_q  <= run_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         err_q      <= err_d;
      end
   end

   // Next-state logic; idle cycles leave everything untouched
   always_comb begin
      state_d    = state_q;
      expect_d   = expect_q;
      run_cnt_d  = run_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (in_valid_i) begin
         case (state_q)
            HUNT: begin
               if (w_match && (run_cnt_q != 4'd0)) begin
                  run_cnt_d = run_cnt_q + 4'd1;
                  expect_d  = seq_next(expect_q);
                  if ((run_cnt_q + 4'd1) == c_lock_tgt) begin
                     state_d    = LOCKED;
                     miss_cnt_d = 4'd0;
                  end
               end else if (seq_legal(in_sym_i)) begin
                  // A legal out-of-order symbol starts a fresh run from itself
                  run_cnt_d = 4'd1;
                  expect_d  = seq_next(in_sym_i);
               end else begin
                  run_cnt_d = 4'd0;
               end
            end
            LOCKED: begin
               // Flywheel: the expected symbol advances whether or not it matched
               expect_d = seq_next(expect_q);
               if (w_match) begin
                  miss_cnt_d = 4'd0;
               end else if ((miss_cnt_q + 4'd1) == c_unlock_tgt) begin
                  state_d    = HUNT;
                  run_cnt_d  = 4'd0;
                  miss_cnt_d = 4'd0;
               end else begin
                  miss_cnt_d = miss_cnt_q + 4'd1;
               end
            end
            default: begin
               state_d = HUNT;
            end
         endcase
      end
   end

   // Output decode: error pulse and counter increments, only while locked
   always_comb begin
      err_d   = 1'b0;
      sym_inc = 1'b0;
      if (in_valid_i && (state_q == LOCKED)) begin
         sym_inc = 1'b1;
         err_d   = !w_match;
      end
      err_inc = err_d;
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_err_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (err_inc),
      .clr_i   (clr_i),
      .count_o (err_count_o)
   );

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_sym_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (sym_inc),
      .clr_i   (clr_i),
      .count_o (sym_count_o)
   );

   assign locked_o = (state_q == LOCKED);
   assign err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_checker
//  Purpose  : Directed self-checking bench for seq_checker. A default
//             instance (CNT_W=16) and a narrow instance (CNT_W=2) share the
//             same stimulus; the narrow one shows counter saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_checker;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [2:0]  in_sym;
   logic        clr;

   logic        locked_w, err_w;
   logic [15:0] err_count_w, sym_count_w;
   logic        locked2_w, err2_w;
   logic [1:0]  err_count2_w, sym_count2_w;

   int n_cmp = 0;
   int n_bad = 0;

   seq_checker #(
      .LOCK_LEN    (4),
      .UNLOCK_ERRS (3),
      .CNT_W       (16)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid),
      .in_sym_i    (in_sym),
      .clr_i       (clr),
      .locked_o    (locked_w),
      .err_o       (err_w),
      .err_count_o (err_count_w),
      .sym_count_o (sym_count_w)
   );

   seq_checker #(
      .LOCK_LEN    (4),
      .UNLOCK_ERRS (3),
      .CNT_W       (2)
   ) u_dut_w2 (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid),
      .in_sym_i    (in_sym),
      .clr_i       (clr),
      .locked_o    (locked2_w),
      .err_o       (err2_w),
      .err_count_o (err_count2_w),
      .sym_count_o (sym_count2_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the stimulus ever stalls
   initial begin
      #200000;
      $display("FAIL watchdog: obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: obs=%0d exp=%0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Present one cycle of input, let the edge sample it, land 1 ns after
   task automatic step(input logic v, input logic [2:0] s, input logic c);
      in_valid = v;
      in_sym   = s;
      clr      = c;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sym   = 3'b000;
      clr      = 1'b0;
   endtask

   task automatic sym(input logic [2:0] s);
      step(1'b1, s, 1'b0);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_sym   = 3'b000;
      clr      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_locked", 32'(locked_w), 32'd0);
      check_eq("rst_err", 32'(err_w), 32'd0);
      check_eq("rst_errcnt", 32'(err_count_w), 32'd0);
      check_eq("rst_symcnt", 32'(sym_count_w), 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ---- Acquire lock with a clean run of four ----
      sym(3'b000);
      sym(3'b010);
      sym(3'b011);
      check_eq("acq_not_yet", 32'(locked_w), 32'd0);
      sym(3'b101);
      check_eq("acq_locked", 32'(locked_w), 32'd1);
      check_eq("acq_err", 32'(err_w), 32'd0);
      check_eq("acq_symcnt", 32'(sym_count_w), 32'd0);

      // ---- Illegal symbol in place of 011; flywheel keeps alignment ----
      sym(3'b000);
      step(1'b1, 3'b010, 1'b1);              // clr beats the increment
      check_eq("clr_prio_sym", 32'(sym_count_w), 32'd0);
      sym(3'b111);
      check_eq("inj_err", 32'(err_w), 32'd1);
      check_eq("inj_errcnt", 32'(err_count_w), 32'd1);
      check_eq("inj_locked", 32'(locked_w), 32'd1);
      sym(3'b101);
      check_eq("fly_err0", 32'(err_w), 32'd0);
      sym(3'b000);
      check_eq("fly_err1", 32'(err_w), 32'd0);
      check_eq("fly_symcnt", 32'(sym_count_w), 32'd3);
      check_eq("fly_errcnt", 32'(err_count_w), 32'd1);

      // ---- Seven idle cycles between 010 and 011 ----
      sym(3'b010);
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 3'b111, 1'b0);
         check_eq("gap_err", 32'(err_w), 32'd0);
      end
      check_eq("gap_locked", 32'(locked_w), 32'd1);
      check_eq("gap_symcnt", 32'(sym_count_w), 32'd4);
      sym(3'b011);
      check_eq("gap_after_err", 32'(err_w), 32'd0);
      sym(3'b101);
      check_eq("gap_symcnt2", 32'(sym_count_w), 32'd6);

      // ---- Three consecutive 001 drop lock, then relock ----
      step(1'b0, 3'b000, 1'b1);
      check_eq("clr_errcnt", 32'(err_count_w), 32'd0);
      check_eq("clr_locked", 32'(locked_w), 32'd1);
      for (int i = 1; i <= 3; i++) begin
         sym(3'b001);
         check_eq("unl_err", 32'(err_w), 32'd1);
         check_eq("unl_errcnt", 32'(err_count_w), 32'(i));
         check_eq("unl_locked", 32'(locked_w), (i == 3) ? 32'd0 : 32'd1);
      end
      sym(3'b000);
      check_eq("hunt_err", 32'(err_w), 32'd0);
      sym(3'b010);
      sym(3'b011);
      check_eq("relock_not_yet", 32'(locked_w), 32'd0);
      sym(3'b101);
      check_eq("relock", 32'(locked_w), 32'd1);
      check_eq("hunt_symcnt", 32'(sym_count_w), 32'd3);
      check_eq("hunt_errcnt", 32'(err_count_w), 32'd3);

      // ---- CNT_W=2 saturation with lock held (expect is 000 now) ----
      step(1'b0, 3'b000, 1'b1);
      sym(3'b111); sym(3'b010);
      sym(3'b111); sym(3'b101);
      sym(3'b111); sym(3'b010);
      sym(3'b111); sym(3'b101);
      sym(3'b111);
      check_eq("sat_errcnt_w2", 32'(err_count2_w), 32'd3);
      check_eq("sat_symcnt_w2", 32'(sym_count2_w), 32'd3);
      check_eq("sat_errcnt_w16", 32'(err_count_w), 32'd5);
      check_eq("sat_locked_w2", 32'(locked2_w), 32'd1);
      step(1'b1, 3'b111, 1'b1);              // mismatch together with clr
      check_eq("sat_clr_err", 32'(err2_w), 32'd1);
      check_eq("sat_clr_errcnt", 32'(err_count2_w), 32'd0);
      check_eq("sat_clr_symcnt", 32'(sym_count2_w), 32'd0);
      check_eq("sat_clr_locked", 32'(locked2_w), 32'd1);

      // ---- Asynchronous reset between edges while locked, err high ----
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_locked", 32'(locked_w), 32'd0);
      check_eq("arst_err", 32'(err_w), 32'd0);
      check_eq("arst_errcnt", 32'(err_count_w), 32'd0);
      check_eq("arst_symcnt", 32'(sym_count_w), 32'd0);
      check_eq("arst_err_w2", 32'(err2_w), 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ---- HUNT: a legal out-of-order symbol restarts the run from itself ----
      sym(3'b000);
      sym(3'b010);
      sym(3'b101);                           // run restarts at 1, expect 000
      sym(3'b000);
      sym(3'b010);
      check_eq("restart_not_yet", 32'(locked_w), 32'd0);
      sym(3'b011);
      check_eq("restart_locked", 32'(locked_w), 32'd1);
      check_eq("restart_err", 32'(err_w), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
